// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM types and constants for the packet UART.
// Imported by the byte engine and the packet framer.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT
   } pkt_state_t;

   typedef enum logic [1:0] {
      B_IDLE,
      START,
      DATA,
      STOP
   } bit_state_t;

   localparam int PKT_BYTES = 6;
   localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

   function automatic logic [7:0] pkt_chk(
      input logic [7:0]  addr,
      input logic [7:0]  mode,
      input logic [15:0] data
   );
      return addr ^ mode ^ data[15:8] ^ data[7:0];
   endfunction

endpackage

// File: rtl/uart_packet_tx_if.sv
// uart_packet_tx_if: record handshake between the arbiter and the packet UART.
// The arbiter pulses data_ready; the UART answers with tx_complete.
interface uart_packet_tx_if;
   logic        data_ready;
   logic [7:0]  toPC_address;
   logic [7:0]  toPC_mode;
   logic [15:0] toPC_data;
   logic        tx_complete;

   modport master (
      output data_ready,
      output toPC_address,
      output toPC_mode,
      output toPC_data,
      input  tx_complete
   );

   modport slave (
      input  data_ready,
      input  toPC_address,
      input  toPC_mode,
      input  toPC_data,
      output tx_complete
   );
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer, LSB first.
// A start seen in the last stop cycle chains the next byte with no gap.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] din,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   bit_state_t  state;
   logic [CW-1:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        bit_end;

   assign bit_end = (cnt == CNT_MAX);
   assign done    = (state == STOP) && bit_end;
   assign busy    = (state != B_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= B_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         unique case (state)
            B_IDLE: begin
               cnt <= '0;
               if (start) begin
                  shreg <= din;
                  state <= START;
                  tx    <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  tx      <= shreg[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (start) begin
                     shreg <= din;
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state <= B_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= B_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: frames one {addr, mode, data} record as a 6-byte packet
// (sync, addr, mode, data hi, data lo, xor checksum) and sends it 8N1.
module uart_packet_tx
   import uart_pkg::*;
#(
   parameter int         CLK_FREQ  = 100_000_000,
   parameter int         BAUD      = 115_200,
   parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC
) (
   input  logic              clk,
   input  logic              reset,
   uart_packet_tx_if.slave   rec,
   output logic              tx,
   output logic              overrun_error
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   pkt_state_t state;
   logic [2:0] idx;
   logic [7:0] addr_q;
   logic [7:0] mode_q;
   logic [7:0] dhi_q;
   logic [7:0] dlo_q;
   logic [7:0] chk_q;
   logic       start_q;
   logic       byte_start;
   logic       byte_busy;
   logic       byte_done;
   logic       last_byte;
   logic       chain;
   logic [2:0] sel;
   logic [7:0] din;

   assign rec.tx_complete = (state == IDLE) & ~rec.data_ready;

   assign last_byte  = (idx == 3'(PKT_BYTES - 1));
   // Next byte is handed over during the current stop bit's last cycle.
   assign chain      = (state == WAIT) && byte_done && !last_byte;
   assign sel        = chain ? idx + 3'd1 : idx;
   assign byte_start = start_q | chain;

   always_comb begin
      din = SYNC_BYTE;
      case (sel)
         3'd0:    din = SYNC_BYTE;
         3'd1:    din = addr_q;
         3'd2:    din = mode_q;
         3'd3:    din = dhi_q;
         3'd4:    din = dlo_q;
         3'd5:    din = chk_q;
         default: din = SYNC_BYTE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= '0;
         start_q       <= 1'b0;
         overrun_error <= 1'b0;
         addr_q        <= '0;
         mode_q        <= '0;
         dhi_q         <= '0;
         dlo_q         <= '0;
         chk_q         <= '0;
      end else begin
         start_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rec.data_ready) begin
                  addr_q <= rec.toPC_address;
                  mode_q <= rec.toPC_mode;
                  dhi_q  <= rec.toPC_data[15:8];
                  dlo_q  <= rec.toPC_data[7:0];
                  chk_q  <= pkt_chk(rec.toPC_address, rec.toPC_mode,
                                    rec.toPC_data);
                  idx    <= '0;
                  state  <= SEND;
               end
            end
            SEND: begin
               start_q <= 1'b1;
               state   <= WAIT;
            end
            WAIT: begin
               if (byte_done) begin
                  if (last_byte) begin
                     state <= IDLE;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else if (!byte_busy && !start_q) begin
                  // Engine idle with no done: never resume a lost packet.
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (rec.data_ready && state != IDLE) begin
            overrun_error <= 1'b1;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk  (clk),
      .reset(reset),
      .start(byte_start),
      .din  (din),
      .tx   (tx),
      .busy (byte_busy),
      .done (byte_done)
   );

endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: random and directed packets against a bit-level
// waveform model of the 6-byte 8N1 packet.
module tb_uart_packet_tx;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 100_000;
   localparam int C        = CLK_FREQ / BAUD;
   localparam int PKT_CYC  = 60 * C;
   localparam logic [7:0] SYNC = 8'hA5;

   logic clk = 1'b0;
   logic reset;
   logic tx;
   logic overrun_error;
   logic ovr_model;
   int   n_cmp = 0;
   int   n_err = 0;

   uart_packet_tx_if rec ();

   uart_packet_tx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .SYNC_BYTE(SYNC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rec          (rec),
      .tx           (tx),
      .overrun_error(overrun_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] make_pkt(input logic [7:0] a,
      input logic [7:0] m, input logic [15:0] d);
      logic [7:0] chk;
      chk = a ^ m ^ d[15:8] ^ d[7:0];
      return {chk, d[7:0], d[15:8], m, a, SYNC};
   endfunction

   // Expected line level j cycles after the first start-bit fall.
   function automatic logic exp_bit(input logic [47:0] pkt, input int j);
      int p;
      p = (j / C) % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return pkt[8 * (j / (10 * C)) + p - 1];
   endfunction

   task automatic idle_check(input string tag, input int n);
      int bad;
      bad = 0;
      repeat (n) begin
         @(negedge clk);
         if (tx !== 1'b1 || rec.tx_complete !== 1'b1) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   task automatic run_packet(input string tag, input logic [7:0] a,
      input logic [7:0] m, input logic [15:0] d,
      input int inj_at, input int rst_at);
      logic [47:0] pkt;
      logic [47:0] got;
      int lat, bad_wave, bad_busy, bad_frame, n, p;
      pkt = make_pkt(a, m, d);
      got = '0;
      rec.data_ready   = 1'b1;
      rec.toPC_address = a;
      rec.toPC_mode    = m;
      rec.toPC_data    = d;
      #1 check({tag, "/ready_low_on_pulse"}, 32'(rec.tx_complete), 32'd0);
      @(negedge clk);
      rec.data_ready   = 1'b0;
      rec.toPC_address = 8'($urandom);
      rec.toPC_mode    = 8'($urandom);
      rec.toPC_data    = 16'($urandom);
      check({tag, "/busy_after_capture"}, 32'(rec.tx_complete), 32'd0);
      lat = 0;
      while (tx !== 1'b0 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "/start_latency"}, 32'(lat), 32'd2);
      bad_wave  = 0;
      bad_busy  = 0;
      bad_frame = 0;
      for (int j = 0; j < PKT_CYC; j++) begin
         if (j == rst_at) begin
            reset = 1'b1;
            @(negedge clk);
            check({tag, "/rst_tx"}, 32'(tx), 32'd1);
            check({tag, "/rst_ready"}, 32'(rec.tx_complete), 32'd1);
            check({tag, "/rst_ovr"}, 32'(overrun_error), 32'd0);
            reset     = 1'b0;
            ovr_model = 1'b0;
            return;
         end
         if (tx !== exp_bit(pkt, j)) bad_wave++;
         if (rec.tx_complete !== 1'b0) bad_busy++;
         if (j % C == C / 2) begin
            n = j / (10 * C);
            p = (j / C) % 10;
            if (p == 0 && tx !== 1'b0) bad_frame++;
            else if (p == 9 && tx !== 1'b1) bad_frame++;
            else if (p >= 1 && p <= 8) got[8 * n + p - 1] = tx;
         end
         if (j == inj_at) begin
            rec.data_ready   = 1'b1;
            rec.toPC_address = 8'hFF;
            rec.toPC_mode    = 8'($urandom);
            rec.toPC_data    = 16'($urandom);
            ovr_model        = 1'b1;
         end else if (j == inj_at + 1) begin
            rec.data_ready = 1'b0;
         end
         @(negedge clk);
      end
      check({tag, "/waveform"}, 32'(bad_wave), 32'd0);
      check({tag, "/busy_during"}, 32'(bad_busy), 32'd0);
      check({tag, "/framing"}, 32'(bad_frame), 32'd0);
      for (int b = 0; b < 6; b++) begin
         check($sformatf("%s/B%0d", tag, b), 32'(got[8 * b +: 8]),
               32'(pkt[8 * b +: 8]));
      end
      check({tag, "/ready_after"}, 32'(rec.tx_complete), 32'd1);
      check({tag, "/tx_idle_after"}, 32'(tx), 32'd1);
      check({tag, "/overrun"}, 32'(overrun_error), 32'(ovr_model));
   endtask

   initial begin
      int inj;
      reset            = 1'b1;
      ovr_model        = 1'b0;
      rec.data_ready   = 1'b0;
      rec.toPC_address = '0;
      rec.toPC_mode    = '0;
      rec.toPC_data    = '0;
      repeat (3) @(negedge clk);
      check("t1/rst_tx", 32'(tx), 32'd1);
      check("t1/rst_ready", 32'(rec.tx_complete), 32'd1);
      check("t1/rst_ovr", 32'(overrun_error), 32'd0);
      reset = 1'b0;
      idle_check("t1/idle100", 100);

      run_packet("t2", 8'h48, 8'h05, 16'h1A2B, -1, -1);
      idle_check("t2/idle", 5);

      run_packet("t3", 8'h48, 8'h05, 16'h1A2B, 150, -1);
      idle_check("t3/idle", 20);
      check("t3/sticky", 32'(overrun_error), 32'd1);

      run_packet("t5", 8'($urandom), 8'($urandom), 16'($urandom),
                 -1, 32 * C + 3);
      idle_check("t5/no_resume", 50);
      run_packet("t5/clean", 8'h3C, 8'h81, 16'hBEEF, -1, -1);

      run_packet("t4a", 8'h12, 8'h34, 16'h5678, -1, -1);
      run_packet("t4b", 8'h9A, 8'hBC, 16'hDEF0, -1, -1);
      idle_check("t4/idle", 3);

      run_packet("t6", 8'h00, 8'h00, 16'h0000, -1, -1);

      for (int r = 0; r < 4; r++) begin
         idle_check($sformatf("rnd%0d/gap", r), int'($urandom_range(4, 1)));
         inj = ($urandom_range(1, 0) == 1)
             ? int'($urandom_range(PKT_CYC - 10, 0)) : -1;
         run_packet($sformatf("rnd%0d", r), 8'($urandom), 8'($urandom),
                    16'($urandom), inj, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
